// File: rtl/aes_dec_pkg.sv
// aes_dec_pkg: shared types and constants for the AES-256 decryption datapath.
package aes_dec_pkg;
    localparam int NR       = 14;
    localparam int NB_BYTES = 16;
    typedef logic [15:0][7:0] state_t;
    typedef logic [3:0]       round_t;
    typedef enum logic [1:0] {IDLE, WAIT_IN, FETCH, HOLD} dec_ark_st_e;
endpackage

// File: rtl/mod_dec_roundCounter.sv
// mod_dec_roundCounter: loadable round down-counter with zero flag; saturates at 0.
module mod_dec_roundCounter
    import aes_dec_pkg::*;
#(
    parameter round_t INIT = round_t'(NR)
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   load,
    input  logic   dec,
    output round_t round,
    output logic   zero
);
    round_t cnt_q, cnt_d;

    always_comb cnt_d = load ? INIT : (dec && cnt_q != '0) ? cnt_q - 4'd1 : cnt_q;

    always_ff @(posedge clk or posedge reset)
        if (reset) cnt_q <= INIT;
        else       cnt_q <= cnt_d;

    assign round = cnt_q;
    assign zero  = (cnt_q == '0);
endmodule

// File: rtl/mod_dec_addroundkey.sv
// mod_dec_addroundkey: inverse-schedule AddRoundKey; fetches keys NR..0 from the key ROM
// and XORs each into one accepted state, presenting a registered result.
module mod_dec_addroundkey #(
    parameter int NR = 14,
    parameter int N  = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*8-1:0] s,
    output logic           key_req,
    output logic [3:0]     key_addr,
    input  logic           key_ack,
    input  logic [127:0]   k,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*8-1:0] o,
    output logic [3:0]     round_out,
    output logic           last,
    output logic           done,
    output logic           busy
);
    import aes_dec_pkg::*;

    dec_ark_st_e    state_q, state_d;
    logic [N*8-1:0] s_q, s_d, o_q, o_d;
    round_t         round_out_q, round_out_d, round;
    logic           last_q, last_d, done_q, done_d;
    logic           zero, accept, ack, cnt_load, cnt_dec;

    mod_dec_roundCounter #(.INIT(round_t'(NR))) u_cnt (
        .clk   (clk),
        .reset (reset),
        .load  (cnt_load),
        .dec   (cnt_dec),
        .round (round),
        .zero  (zero)
    );

    always_ff @(posedge clk or posedge reset)
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)     state_d = WAIT_IN;
            WAIT_IN: if (in_valid)  state_d = FETCH;
            FETCH:   if (key_ack)   state_d = HOLD;
            HOLD:    if (out_ready) state_d = zero ? IDLE : WAIT_IN;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == WAIT_IN);
        key_req   = (state_q == FETCH);
        key_addr  = key_req ? round : '0;
        out_valid = (state_q == HOLD);
        busy      = (state_q != IDLE);
        last      = out_valid & last_q;
    end

    // Key ROM and the input side only act in their own states; stray strobes fall through.
    always_comb begin
        accept      = in_ready & in_valid;
        ack         = key_req & key_ack;
        s_d         = accept ? s : s_q;
        o_d         = ack ? s_q ^ k[N*8-1:0] : o_q;
        round_out_d = ack ? round : round_out_q;
        last_d      = ack ? zero : last_q;
        done_d      = out_valid & out_ready & zero;
        cnt_load    = ((state_q == IDLE) & start) | done_d;
        cnt_dec     = out_valid & out_ready & ~zero;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            s_q         <= '0;
            o_q         <= '0;
            round_out_q <= '0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            s_q         <= s_d;
            o_q         <= o_d;
            round_out_q <= round_out_d;
            last_q      <= last_d;
            done_q      <= done_d;
        end

    assign o         = o_q;
    assign round_out = round_out_q;
    assign done      = done_q;
endmodule

// File: tb/tb_mod_dec_addroundkey.sv
// tb_mod_dec_addroundkey: directed stimulus with a queue scoreboard checked by an output monitor.
module tb_mod_dec_addroundkey;
    logic         clk = 1'b0, reset, start, in_valid, key_ack, out_ready;
    logic [127:0] s, k, o;
    logic [3:0]   key_addr, round_out;
    logic         in_ready, key_req, out_valid, last, done, busy;

    typedef struct packed {logic [127:0] o; logic [3:0] r; logic l;} exp_t;
    exp_t q[$];
    int total = 0, bad = 0, done_cnt = 0;

    localparam logic [127:0] KINC = 128'h0f0e0d0c0b0a09080706050403020100;

    always #5 clk = ~clk;

    mod_dec_addroundkey dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .s(s), .key_req(key_req), .key_addr(key_addr), .key_ack(key_ack), .k(k),
        .out_valid(out_valid), .out_ready(out_ready), .o(o), .round_out(round_out),
        .last(last), .done(done), .busy(busy)
    );

    task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (out_valid && out_ready) begin
            exp_t e;
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected got=%h want=none", o);
            end else begin
                e = q.pop_front();
                chk("sb_o", o, e.o);
                chk("sb_round", round_out, e.r);
                chk("sb_last", last, e.l);
            end
        end
    end

    task automatic run_round(input logic [127:0] sv, input logic [3:0] r, input logic [127:0] kv,
                             input int wt, input bit poke);
        int n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        chk("in_ready", in_ready, 1);
        in_valid = 1; s = sv;
        tick();
        in_valid = 0;
        chk("key_req", key_req, 1);
        chk("key_addr", key_addr, r);
        for (int i = 0; i < wt; i++) begin
            start = poke && i == 0;
            tick();
            start = 0;
            chk("req_hold", key_req, 1);
            chk("addr_hold", key_addr, r);
            chk("no_early_valid", out_valid, 0);
        end
        chk("pre_ack_valid", out_valid, 0);
        q.push_back('{o: sv ^ kv, r: r, l: (r == 4'd0)});
        key_ack = 1; k = kv;
        tick();
        key_ack = 0;
        chk("valid_lat", out_valid, 1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 10) begin
            tick();
            n++;
        end
        chk("done", done, 1);
        chk("idle_busy", busy, 0);
        chk("idle_in_ready", in_ready, 0);
        tick();
        chk("done_pulse", done, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        reset = 1; start = 0; in_valid = 0; key_ack = 0; out_ready = 0; s = '0; k = '0;
        repeat (3) tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_key_req", key_req, 0);
        chk("rst_key_addr", key_addr, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_o", o, 0);
        chk("rst_round_out", round_out, 0);
        chk("rst_last", last, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        reset = 0;
        tick();
        chk("idle_no_ready", in_ready, 0);

        start = 1;
        tick();
        start = 0;
        chk("start_busy", busy, 1);
        run_round('0, 4'd14, KINC, 0, 0);
        chk("single_o", o, KINC);
        chk("single_round", round_out, 14);
        chk("single_last", last, 0);

        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", out_valid, 1);
            chk("bp_o", o, KINC);
            chk("bp_round", round_out, 14);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_key_req", key_req, 0);
        end
        out_ready = 1;
        tick();
        out_ready = 0;

        key_ack = 1; k = '1;
        tick();
        key_ack = 0;
        chk("stray_ack_ready", in_ready, 1);
        chk("stray_ack_req", key_req, 0);
        chk("stray_ack_o", o, KINC);
        chk("stray_ack_valid", out_valid, 0);
        run_round({16{8'h5A}}, 4'd13, {16{8'h0D}}, 4, 1);
        chk("wait_o", o, {16{8'h57}});
        chk("wait_round", round_out, 13);

        out_ready = 1;
        for (int r = 12; r >= 0; r--)
            run_round({16{8'hC3}}, 4'(r), {16{4'h0, 4'(r)}}, 0, 0);
        wait_done();
        chk("done_count1", done_cnt, 1);

        start = 1;
        tick();
        start = 0;
        in_valid = 1; s = '1;
        tick();
        in_valid = 0;
        chk("mid_req", key_req, 1);
        reset = 1;
        tick();
        chk("mid_rst_req", key_req, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_o", o, 0);
        chk("mid_rst_busy", busy, 0);
        reset = 0;
        tick();

        start = 1;
        tick();
        start = 0;
        for (int r = 14; r >= 0; r--)
            run_round({16{8'hFF}}, 4'(r), {16{4'h0, 4'(r)}}, 0, 0);
        chk("full_last_o", o, {16{8'hFF}});
        wait_done();
        chk("done_count2", done_cnt, 2);
        chk("sb_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
